// File: rtl/mem_access_unit_if.sv
// Bundles the controller strobes, memory handshake and capture registers of the memory-access stage.
// master = the access unit; slave = controller + memory side.
interface mem_access_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              MemRead;
   logic              MemWrite;
   logic              IorD;
   logic              IRWrite;
   logic [ADDR_W-1:0] PC;
   logic [ADDR_W-1:0] ALUOut;
   logic [DATA_W-1:0] WriteData;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic [DATA_W-1:0] IR;
   logic [DATA_W-1:0] MDR;
   logic              MemBusy;
   logic              MemDone;
   logic              MemErr;

   modport master (
      input  MemRead, MemWrite, IorD, IRWrite, PC, ALUOut, WriteData,
      input  mem_rdata, mem_ack,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output IR, MDR, MemBusy, MemDone, MemErr
   );

   modport slave (
      output MemRead, MemWrite, IorD, IRWrite, PC, ALUOut, WriteData,
      output mem_rdata, mem_ack,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  IR, MDR, MemBusy, MemDone, MemErr
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access stage: address select, wait-state handshake with timeout, IR/MDR capture.
// The controller stalls on MemBusy; MemDone pulses for the single DONE cycle.
module mem_access_unit #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   mem_access_unit_if.master  bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

   // Timeout fires on the edge where the counter already holds TIMEOUT-1.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ir_sel_q, ir_sel_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] sel_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         ir_sel_q <= 1'b0;
         ir_q     <= '0;
         mdr_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         ir_sel_q <= ir_sel_d;
         ir_q     <= ir_d;
         mdr_q    <= mdr_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      ir_sel_d = ir_sel_q;
      ir_d     = ir_q;
      mdr_d    = mdr_q;
      err_d    = err_q;
      sel_addr = bus.IorD ? bus.ALUOut : bus.PC;
      case (state_q)
         IDLE: begin
            if (bus.MemRead && bus.MemWrite) begin
               err_d = 1'b1;
            end else if (bus.MemRead || bus.MemWrite) begin
               if (sel_addr[1:0] != 2'b00) begin
                  err_d = 1'b1;
               end else begin
                  addr_d   = sel_addr;
                  we_d     = bus.MemWrite;
                  wdata_d  = bus.WriteData;
                  ir_sel_d = bus.IRWrite & bus.MemRead & ~bus.IorD;
                  cnt_d    = '0;
                  state_d  = WAIT;
               end
            end
         end
         WAIT: begin
            // Ack is tested first so it wins over a coincident timeout.
            if (bus.mem_ack) begin
               if (!we_q) begin
                  mdr_d = bus.mem_rdata;
                  if (ir_sel_q) ir_d = bus.mem_rdata;
               end
               cnt_d   = '0;
               state_d = DONE;
            end else if (cnt_q == TO_LAST) begin
               cnt_d   = '0;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // mem_req follows the state so an asynchronous reset drops it at once.
   always_comb begin
      bus.mem_req   = (state_q == WAIT);
      bus.MemBusy   = (state_q != IDLE);
      bus.MemDone   = (state_q == DONE);
      bus.mem_we    = we_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.IR        = ir_q;
      bus.MDR       = mdr_q;
      bus.MemErr    = err_q;
   end
endmodule
